// File: rtl/axi_grid_req_link_mux.sv
// rtl/axi_grid_req_link_mux.sv - round-robin AW/W/AR request mux onto one grid link with 2-entry skid buffer
`timescale 1ns/1ps
module axi_grid_req_link_mux #(
  parameter int PAYLOAD_W = 64,
  parameter int LOCK_W    = 1
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [PAYLOAD_W-1:0] aw_payload_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic [PAYLOAD_W-1:0] w_payload_i,
  input  logic                 w_last_i,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [PAYLOAD_W-1:0] ar_payload_i,
  output logic                 link_valid_o,
  input  logic                 link_ready_i,
  output logic [1:0]           link_chan_o,
  output logic [PAYLOAD_W-1:0] link_payload_o,
  output logic                 link_last_o
);

  localparam logic [1:0] CH_AW = 2'd0;
  localparam logic [1:0] CH_W  = 2'd1;
  localparam logic [1:0] CH_AR = 2'd2;

  typedef struct packed {
    logic [1:0]           chan;
    logic                 last;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  logic [1:0] count_q, count_d;
  entry_t     ent0_q, ent0_d;
  entry_t     ent1_q, ent1_d;
  logic       lock_q, lock_d;
  logic [1:0] last_grant_q, last_grant_d;

  logic       space;
  logic [2:0] valid_vec;
  logic [1:0] o0, o1, o2;
  logic       grant;
  logic [1:0] grant_chan;
  entry_t     push_entry;
  logic       pop;

  // Arbitration: lock restricts to W, otherwise cyclic search after the last grant.
  // Space depends only on the registered count, never on link_ready_i.
  always_comb begin
    space      = (count_q != 2'd2);
    valid_vec  = {ar_valid_i, w_valid_i, aw_valid_i};
    grant      = 1'b0;
    grant_chan = CH_AW;
    case (last_grant_q)
      CH_AW:   begin o0 = CH_W;  o1 = CH_AR; o2 = CH_AW; end
      CH_W:    begin o0 = CH_AR; o1 = CH_AW; o2 = CH_W;  end
      default: begin o0 = CH_AW; o1 = CH_W;  o2 = CH_AR; end
    endcase
    if (arst_ni && space) begin
      if (lock_q) begin
        if (w_valid_i) begin
          grant      = 1'b1;
          grant_chan = CH_W;
        end
      end else if (valid_vec[o0]) begin
        grant      = 1'b1;
        grant_chan = o0;
      end else if (valid_vec[o1]) begin
        grant      = 1'b1;
        grant_chan = o1;
      end else if (valid_vec[o2]) begin
        grant      = 1'b1;
        grant_chan = o2;
      end
    end
    aw_ready_o = grant && (grant_chan == CH_AW);
    w_ready_o  = grant && (grant_chan == CH_W);
    ar_ready_o = grant && (grant_chan == CH_AR);
    push_entry.chan = grant_chan;
    case (grant_chan)
      CH_W: begin
        push_entry.last    = w_last_i;
        push_entry.payload = w_payload_i;
      end
      CH_AR: begin
        push_entry.last    = 1'b1;
        push_entry.payload = ar_payload_i;
      end
      default: begin
        push_entry.last    = 1'b1;
        push_entry.payload = aw_payload_i;
      end
    endcase
  end

  // Skid buffer, lock and round-robin pointer next state; head entry stays in ent0 and
  // keeps its last value once the buffer drains.
  always_comb begin
    pop          = (count_q != 2'd0) && link_ready_i;
    count_d      = count_q + {1'b0, grant} - {1'b0, pop};
    ent0_d       = ent0_q;
    ent1_d       = ent1_q;
    lock_d       = lock_q;
    last_grant_d = last_grant_q;
    if (pop && (count_q == 2'd2)) begin
      ent0_d = ent1_q;
    end
    if (grant) begin
      if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
        ent0_d = push_entry;
      end else begin
        ent1_d = push_entry;
      end
      last_grant_d = grant_chan;
      if (grant_chan == CH_W) begin
        lock_d = (LOCK_W != 0) && !w_last_i;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      count_q      <= 2'd0;
      ent0_q       <= '0;
      ent1_q       <= '0;
      lock_q       <= 1'b0;
      last_grant_q <= CH_AR;
    end else begin
      count_q      <= count_d;
      ent0_q       <= ent0_d;
      ent1_q       <= ent1_d;
      lock_q       <= lock_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign link_valid_o   = (count_q != 2'd0);
  assign link_chan_o    = ent0_q.chan;
  assign link_last_o    = ent0_q.last;
  assign link_payload_o = ent0_q.payload;

endmodule

// File: tb/tb_axi_grid_req_link_mux.sv
// tb/tb_axi_grid_req_link_mux.sv - directed and random self-checking bench for axi_grid_req_link_mux
`timescale 1ns/1ps
module tb_axi_grid_req_link_mux;

  logic        clk_i = 1'b0;
  logic        arst_ni;
  logic        aw_valid_i, aw_ready_o;
  logic [63:0] aw_payload_i;
  logic        w_valid_i, w_ready_o, w_last_i;
  logic [63:0] w_payload_i;
  logic        ar_valid_i, ar_ready_o;
  logic [63:0] ar_payload_i;
  logic        link_valid_o, link_ready_i, link_last_o;
  logic [1:0]  link_chan_o;
  logic [63:0] link_payload_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  axi_grid_req_link_mux #(.PAYLOAD_W(64), .LOCK_W(1)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_payload_i(aw_payload_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_payload_i(w_payload_i), .w_last_i(w_last_i),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_payload_i(ar_payload_i),
    .link_valid_o(link_valid_o), .link_ready_i(link_ready_i), .link_chan_o(link_chan_o),
    .link_payload_o(link_payload_o), .link_last_o(link_last_o)
  );

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic clear_inputs();
    aw_valid_i = 0; w_valid_i = 0; ar_valid_i = 0; w_last_i = 0;
    aw_payload_i = '0; w_payload_i = '0; ar_payload_i = '0; link_ready_i = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    arst_ni = 0;
    step();
    arst_ni = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    arst_ni = 0;
    aw_valid_i = 1; w_valid_i = 1; ar_valid_i = 1; link_ready_i = 1;
    step();
    #1;
    n_cmp++;
    if ({link_valid_o, link_chan_o, link_last_o, link_payload_o} !== 68'h0) begin
      n_bad++; $display("FAIL reset_link got v=%0b c=%0d l=%0b p=%h want all 0", link_valid_o, link_chan_o, link_last_o, link_payload_o);
    end
    n_cmp++;
    if ({ar_ready_o, w_ready_o, aw_ready_o} !== 3'b000) begin
      n_bad++; $display("FAIL reset_ready got %b want 000", {ar_ready_o, w_ready_o, aw_ready_o});
    end
    clear_inputs();
    arst_ni = 1;
  endtask

  task automatic test_round_robin();
    do_reset();
    aw_valid_i = 1; w_valid_i = 1; ar_valid_i = 1; w_last_i = 1; link_ready_i = 1;
    aw_payload_i = 64'hA; w_payload_i = 64'hB; ar_payload_i = 64'hC;
    for (int k = 0; k < 7; k++) begin
      logic [2:0]  er;
      logic [1:0]  ec;
      logic [63:0] ep;
      #1;
      er = 3'b001 << (k % 3);
      n_cmp++;
      if ({ar_ready_o, w_ready_o, aw_ready_o} !== er) begin
        n_bad++; $display("FAIL rr_ready k=%0d got %b want %b", k, {ar_ready_o, w_ready_o, aw_ready_o}, er);
      end
      n_cmp++;
      if (link_valid_o !== (k > 0)) begin
        n_bad++; $display("FAIL rr_valid k=%0d got %b want %b", k, link_valid_o, (k > 0));
      end
      if (k > 0) begin
        ec = 2'((k - 1) % 3);
        ep = 64'hA + 64'(ec);
        n_cmp++;
        if (link_chan_o !== ec || link_payload_o !== ep) begin
          n_bad++; $display("FAIL rr_link k=%0d got c=%0d p=%h want c=%0d p=%h", k, link_chan_o, link_payload_o, ec, ep);
        end
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_w_burst();
    logic [2:0] er [6] = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b010, 3'b100};
    logic [1:0] ec [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    logic       el [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    aw_valid_i = 1; w_valid_i = 1; ar_valid_i = 1; link_ready_i = 1;
    for (int k = 0; k < 7; k++) begin
      w_last_i = (k == 4);
      #1;
      if (k < 6) begin
        n_cmp++;
        if ({ar_ready_o, w_ready_o, aw_ready_o} !== er[k]) begin
          n_bad++; $display("FAIL burst_ready k=%0d got %b want %b", k, {ar_ready_o, w_ready_o, aw_ready_o}, er[k]);
        end
      end
      if (k > 0) begin
        n_cmp++;
        if (link_valid_o !== 1'b1 || link_chan_o !== ec[k-1] || link_last_o !== el[k-1]) begin
          n_bad++; $display("FAIL burst_link k=%0d got v=%b c=%0d l=%b want v=1 c=%0d l=%b", k, link_valid_o, link_chan_o, link_last_o, ec[k-1], el[k-1]);
        end
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    logic        lr [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    logic        av [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    logic        er [8] = '{1, 1, 0, 0, 0, 1, 0, 0};
    logic        ev [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    logic [63:0] ep [8] = '{64'd0, 64'd100, 64'd100, 64'd100, 64'd100, 64'd101, 64'd102, 64'd102};
    int acc = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      link_ready_i = lr[k];
      aw_valid_i   = av[k];
      aw_payload_i = 64'(100 + acc);
      #1;
      n_cmp++;
      if (aw_ready_o !== er[k]) begin
        n_bad++; $display("FAIL bp_ready k=%0d got %b want %b", k, aw_ready_o, er[k]);
      end
      n_cmp++;
      if (link_valid_o !== ev[k]) begin
        n_bad++; $display("FAIL bp_valid k=%0d got %b want %b", k, link_valid_o, ev[k]);
      end
      if (k > 0) begin
        n_cmp++;
        if (link_payload_o !== ep[k] || link_chan_o !== 2'd0) begin
          n_bad++; $display("FAIL bp_payload k=%0d got %h c=%0d want %h c=0", k, link_payload_o, link_chan_o, ep[k]);
        end
      end
      if (aw_valid_i && aw_ready_o) acc++;
      step();
    end
    clear_inputs();
  endtask

  task automatic test_ar_single();
    do_reset();
    ar_valid_i = 1; ar_payload_i = 64'hDEAD_BEEF_0000_0001; link_ready_i = 1;
    #1;
    n_cmp++;
    if ({ar_ready_o, w_ready_o, aw_ready_o} !== 3'b100 || link_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL ar_accept got rdy=%b v=%b want rdy=100 v=0", {ar_ready_o, w_ready_o, aw_ready_o}, link_valid_o);
    end
    step();
    ar_valid_i = 0;
    #1;
    n_cmp++;
    if (link_valid_o !== 1'b1 || link_chan_o !== 2'd2 || link_last_o !== 1'b1 || link_payload_o !== 64'hDEAD_BEEF_0000_0001) begin
      n_bad++; $display("FAIL ar_link got v=%b c=%0d l=%b p=%h want v=1 c=2 l=1 p=deadbeef00000001", link_valid_o, link_chan_o, link_last_o, link_payload_o);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    w_valid_i = 1; w_last_i = 0; w_payload_i = 64'h55; link_ready_i = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (w_ready_o !== (k < 2)) begin
        n_bad++; $display("FAIL midrst_fill k=%0d got %b want %b", k, w_ready_o, (k < 2));
      end
      if (k == 2) arst_ni = 0;
      step();
    end
    arst_ni = 1;
    aw_valid_i = 1; ar_valid_i = 1; link_ready_i = 1;
    #1;
    n_cmp++;
    if (link_valid_o !== 1'b0 || link_payload_o !== 64'h0) begin
      n_bad++; $display("FAIL midrst_empty got v=%b p=%h want v=0 p=0", link_valid_o, link_payload_o);
    end
    n_cmp++;
    if ({ar_ready_o, w_ready_o, aw_ready_o} !== 3'b001) begin
      n_bad++; $display("FAIL midrst_grant got %b want 001", {ar_ready_o, w_ready_o, aw_ready_o});
    end
    step();
    #1;
    n_cmp++;
    if (link_valid_o !== 1'b1 || link_chan_o !== 2'd0) begin
      n_bad++; $display("FAIL midrst_link got v=%b c=%0d want v=1 c=0", link_valid_o, link_chan_o);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_stress();
    logic [64:0] q_aw[$], q_w[$], q_ar[$];
    logic [64:0] exp_e, got_e;
    logic [63:0] seq = 64'h1000;
    logic        prev_hold = 0;
    logic [1:0]  prev_c = 0;
    logic [63:0] prev_p = 0;
    logic        prev_l = 0;
    logic        in_burst = 0;
    logic        acc_aw, acc_w, acc_ar, has;
    do_reset();
    for (int cyc = 0; cyc < 10004; cyc++) begin
      logic active;
      active = (cyc < 10000);
      if (active && !aw_valid_i && $urandom_range(0, 2) != 0) begin
        aw_valid_i = 1; aw_payload_i = seq; seq++;
      end
      if (active && !w_valid_i && $urandom_range(0, 2) != 0) begin
        w_valid_i = 1; w_payload_i = seq; seq++; w_last_i = ($urandom_range(0, 3) == 0);
      end
      if (active && !ar_valid_i && $urandom_range(0, 2) != 0) begin
        ar_valid_i = 1; ar_payload_i = seq; seq++;
      end
      link_ready_i = active ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      n_cmp++;
      if ((aw_ready_o && !aw_valid_i) || (w_ready_o && !w_valid_i) || (ar_ready_o && !ar_valid_i) ||
          $countones({ar_ready_o, w_ready_o, aw_ready_o}) > 1) begin
        n_bad++; $display("FAIL st_ready cyc=%0d got rdy=%b vld=%b", cyc, {ar_ready_o, w_ready_o, aw_ready_o}, {ar_valid_i, w_valid_i, aw_valid_i});
      end
      if (prev_hold) begin
        n_cmp++;
        if (link_valid_o !== 1'b1 || link_chan_o !== prev_c || link_payload_o !== prev_p || link_last_o !== prev_l) begin
          n_bad++; $display("FAIL st_stable cyc=%0d got v=%b c=%0d p=%h want v=1 c=%0d p=%h", cyc, link_valid_o, link_chan_o, link_payload_o, prev_c, prev_p);
        end
      end
      if (link_valid_o && link_ready_i) begin
        got_e = {link_last_o, link_payload_o};
        has = 0;
        exp_e = '0;
        case (link_chan_o)
          2'd0: if (q_aw.size() > 0) begin exp_e = q_aw.pop_front(); has = 1; end
          2'd1: if (q_w.size() > 0) begin exp_e = q_w.pop_front(); has = 1; end
          2'd2: if (q_ar.size() > 0) begin exp_e = q_ar.pop_front(); has = 1; end
          default: has = 0;
        endcase
        n_cmp++;
        if (!has || got_e !== exp_e) begin
          n_bad++; $display("FAIL st_order cyc=%0d chan=%0d got %h want %h (queued=%b)", cyc, link_chan_o, got_e, exp_e, has);
        end
        n_cmp++;
        if (in_burst && link_chan_o !== 2'd1) begin
          n_bad++; $display("FAIL st_burst cyc=%0d got chan=%0d want 1", cyc, link_chan_o);
        end
        in_burst = (link_chan_o == 2'd1) && !link_last_o;
      end
      acc_aw = aw_valid_i && aw_ready_o;
      acc_w  = w_valid_i && w_ready_o;
      acc_ar = ar_valid_i && ar_ready_o;
      if (acc_aw) q_aw.push_back({1'b1, aw_payload_i});
      if (acc_w)  q_w.push_back({w_last_i, w_payload_i});
      if (acc_ar) q_ar.push_back({1'b1, ar_payload_i});
      prev_hold = link_valid_o && !link_ready_i;
      prev_c = link_chan_o; prev_p = link_payload_o; prev_l = link_last_o;
      step();
      if (acc_aw || !active) aw_valid_i = 0;
      if (acc_w  || !active) w_valid_i = 0;
      if (acc_ar || !active) ar_valid_i = 0;
    end
    n_cmp++;
    if (q_aw.size() + q_w.size() + q_ar.size() != 0 || link_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL st_drain got left aw=%0d w=%0d ar=%0d v=%b want 0", q_aw.size(), q_w.size(), q_ar.size(), link_valid_o);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    arst_ni = 0;
    @(negedge clk_i);
    test_reset();
    test_round_robin();
    test_w_burst();
    test_backpressure();
    test_ar_single();
    test_reset_mid();
    test_stress();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_grid_req_link_mux.md
Name: axi_grid_req_link_mux

Overview:
- Sits directly downstream of the AXI grid network interface, between its request-side outputs (AW, W, AR) and the router injection port.
- Serialises the three request channels onto one grid link, with fair round-robin arbitration.
- Keeps W bursts atomic by locking the grant until the last beat is accepted.
- Decouples the router through a 2-entry output skid buffer, so no input ready depends combinationally on link_ready_i.

Parameters:
- PAYLOAD_W, 64: width of every channel payload and of the link payload, in bits.
- LOCK_W, 1: 1 = W bursts are atomic on the link; 0 = W beats arbitrate individually.

Ports:
- clk_i  input  1  clock
- arst_ni  input  1  reset; one clock; reset is synchronous and active-low
- aw_valid_i  input  1  AW flit valid
- aw_ready_o  output  1  AW flit accepted
- aw_payload_i  input  PAYLOAD_W  AW flit payload
- w_valid_i  input  1  W flit valid
- w_ready_o  output  1  W flit accepted
- w_payload_i  input  PAYLOAD_W  W flit payload
- w_last_i  input  1  last beat of the W burst
- ar_valid_i  input  1  AR flit valid
- ar_ready_o  output  1  AR flit accepted
- ar_payload_i  input  PAYLOAD_W  AR flit payload
- link_valid_o  output  1  link flit valid
- link_ready_i  input  1  router accepts the link flit
- link_chan_o  output  2  channel code: 0=AW, 1=W, 2=AR (3 is never driven)
- link_payload_o  output  PAYLOAD_W  link flit payload
- link_last_o  output  1  1 for AW/AR flits; w_last_i for W flits

Behaviour:
- Reset is sampled on rising clk_i while arst_ni=0. Reset values:
  - buffer count=0
  - link_valid_o=0, link_chan_o=0, link_payload_o=0, link_last_o=0
  - all *_ready_o=0
  - lock=0
  - last_grant=AR, so AW has top priority first
- Reset mid-operation discards buffered flits and clears the lock. Flits already handshaken are lost; the upstream must not rely on them.
- space = (count<2). It is a registered-state function only and is independent of link_ready_i.
- Arbitration, each cycle with space=1 and lock=0:
  - Search order is cyclic AW→W→AR, starting at the channel after last_grant.
  - The first valid channel is granted and only that channel's ready_o=1.
  - last_grant updates on a grant.
- When lock=1, only W is eligible: w_ready_o=space, aw_ready_o=ar_ready_o=0.
- Lock control:
  - Lock sets when a W beat with w_last_i=0 is accepted and LOCK_W=1.
  - Lock clears when a W beat with w_last_i=1 is accepted.
- A ready_o is never asserted for an invalid channel. Ready may rise in the same cycle valid rises (combinational from valid + registered state).
- Buffer: 2-entry FIFO with entries {chan, last, payload}.
  - Push on grant; pop on link_valid_o && link_ready_i.
  - Simultaneous push and pop leaves count unchanged.
  - link_valid_o = (count>0); link outputs show the head entry.
  - Pushing into an empty buffer makes link_valid_o rise on the next cycle.
- Latency is 1 cycle from input handshake to link_valid_o.
- Throughput is 1 flit/cycle sustained when link_ready_i=1.
- Full (count=2): all ready_o=0 and the arbiter state holds.
- Empty: link_valid_o=0 and link outputs hold their last popped values.
- Flit order within a channel is preserved. Link payload is never changed while link_valid_o=1 && !link_ready_i.
- A single-beat W (w_last_i=1) never sets lock.

Test Plan:
1. Reset, then AW, W and AR all valid continuously with link_ready_i=1, all W last=1 → link_chan_o sequence 0,1,2,0,1,2…; first link_valid_o 1 cycle after the first aw_ready_o.
2. 4-beat W burst (last on beat 4) started while AW and AR are held valid → link shows four consecutive chan=1 flits; aw_ready_o/ar_ready_o stay 0 until beat 4 is accepted; next grant is AR.
3. link_ready_i=0 with AW valid → exactly 2 AW flits accepted, then aw_ready_o=0 and link payload stable. Raise link_ready_i → flits drain in order, and accepts resume the same cycle count drops below 2.
4. Payload 0xDEAD_BEEF_0000_0001 on AR only → link_chan_o=2, link_last_o=1, payload matches, latency 1 cycle.
5. arst_ni=0 for 1 cycle mid W burst with 2 flits buffered → next cycle count=0, link_valid_o=0, lock=0; AW is granted first after release.
6. Random valid/ready stress over 10k cycles → scoreboard checks per-channel order, no lost or duplicated flits, no interleaving inside W bursts, and no chan=3.
